alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32: WAIT-state cycle limit for multiply completion; legal range 2..255.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset.
REQ-004 In_valid  input  1  operation request present.
REQ-005 In_ready  output  1  controller accepts a request this cycle.
REQ-006 Op_A  input  4  operand A.
REQ-007 Op_B  input  4  operand B.
REQ-008 Op_Sel  input  2  opcode: 00 add, 01 sub, 10 mul, 11 and.
REQ-009 Alu_A  output  4  registered operand A to ALU.
REQ-010 Alu_B  output  4  registered operand B to ALU.
REQ-011 Alu_Select  output  2  registered opcode to ALU.
REQ-012 Alu_Init  output  1  one-cycle multiply start pulse to ALU.
REQ-013 Alu_Sal  input  8  ALU result.
REQ-014 Alu_Cout  input  1  ALU carry/borrow out.
REQ-015 Alu_Done  input  1  ALU multiply complete.
REQ-016 Out_valid  output  1  result available.
REQ-017 Out_ready  input  1  consumer takes result.
REQ-018 Res  output  8  captured result.
REQ-019 Res_Cout  output  1  captured carry.
REQ-020 Err_timeout  output  1  result produced by watchdog, not by ALU.

Function
REQ-021 States SHALL be IDLE, EXEC, INIT, WAIT, HOLD; exactly one active per cycle.
REQ-022 IDLE: In_ready=1; on In_valid&In_ready at an edge, Op_A/Op_B/Op_Sel latched into Alu_A/Alu_B/Alu_Select; next state INIT if Op_Sel=10, else EXEC.
REQ-023 Alu_A, Alu_B, Alu_Select SHALL hold stable from accept until return to IDLE.
REQ-024 EXEC (one cycle): at its ending edge Res<=Alu_Sal, Res_Cout<=Alu_Cout, Err_timeout<=0; next HOLD.
REQ-025 Add/sub/and latency: Out_valid high exactly 2 edges after the accept edge.
REQ-026 INIT (one cycle): Alu_Init=1 only in this state; wait counter cleared; next WAIT.
REQ-027 WAIT: counter increments every cycle; Alu_Done ignored in first WAIT cycle (guard against stale Done); from second WAIT cycle, Alu_Done=1 captures Res<=Alu_Sal, Res_Cout<=0, Err_timeout<=0, next HOLD.
REQ-028 WAIT timeout: if Alu_Done not seen by counter=TIMEOUT_CYC-1, Res<=0, Res_Cout<=0, Err_timeout<=1, next HOLD; Done and timeout in same cycle SHALL resolve as Done.
REQ-029 HOLD: Out_valid=1, In_ready=0, Res/Res_Cout/Err_timeout stable; on Out_ready=1 next IDLE; no same-cycle accept of a new request.
REQ-030 Out_ready asserted outside HOLD SHALL have no effect; In_valid outside IDLE SHALL be ignored (request held by producer).
REQ-031 Res carries full 8 bits of Alu_Sal for all opcodes; no sign extension or masking applied.

Reset
REQ-032 Rst_n low SHALL immediately force IDLE, counter 0, Alu_A/Alu_B/Res=0, Alu_Select=00, Alu_Init=0, Out_valid=0, Res_Cout=0, Err_timeout=0, In_ready=0.
REQ-033 In_ready SHALL rise in the first cycle after Rst_n deasserts; reset in any state (incl. WAIT, HOLD) discards the operation with no Out_valid.

Configuration
REQ-034 Macro ALU_CTRL_TIMEOUT_EN defined: watchdog per REQ-028 present.
REQ-035 Macro undefined: no timeout, WAIT waits indefinitely for Alu_Done, Err_timeout tied 0, TIMEOUT_CYC unused.

Verification
REQ-036 Add A=9,B=8, Out_ready=1 -> Out_valid 2 edges after accept, Res=0x01, Res_Cout=1, Err_timeout=0.
REQ-037 Sub A=3,B=5 -> Res=0x0E, Res_Cout=0; Alu_Init never asserted.
REQ-038 Mul A=7,B=6, ALU model asserts Done 10 cycles after Init -> single Alu_Init pulse, Res=0x2A, Out_valid one edge after Done; Done high in first WAIT cycle ignored.
REQ-039 Mul with Alu_Done stuck 0, TIMEOUT_CYC=32, macro defined -> HOLD after 32 WAIT cycles, Res=0, Err_timeout=1; macro undefined -> stays in WAIT for 100+ cycles.
REQ-040 And A=0xC,B=0xA, Out_ready low 5 cycles -> Res=0x08 stable, Out_valid=1, In_ready=0 throughout; IDLE one edge after Out_ready=1.
REQ-041 Rst_n pulsed low during WAIT -> Alu_Init/Out_valid 0 immediately, all outputs at reset values, next request processed normally.

Source files
------------

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Purpose
//   Sequencing controller between a request/response handshake and a small
//   4-bit ALU. It accepts one operation at a time, registers the operands and
//   opcode towards the ALU, and captures the 8-bit result and carry into an
//   output register. The result is held until the consumer takes it.
//   Add, sub and and are single-cycle operations (EXEC). Multiply is
//   multi-cycle: a start pulse (INIT) is sent, then the controller waits
//   (WAIT) for the ALU's done strobe.
//
// Optional feature
//   ALU_CTRL_TIMEOUT_EN : when defined, a watchdog ends a multiply that has
//                         not completed within TIMEOUT_CYC WAIT cycles. The
//                         watchdog returns a zero result with o_err_timeout
//                         set. When undefined, WAIT lasts until i_alu_done
//                         arrives and o_err_timeout is tied low.
//
// Parameters
//   TIMEOUT_CYC   WAIT-state cycle limit for multiply completion (2..255)
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in_valid     operation request present
//   o_in_ready     controller accepts a request this cycle
//   i_op_a/i_op_b  4-bit operands
//   i_op_sel       opcode: 00 add, 01 sub, 10 mul, 11 and
//   o_alu_a/o_alu_b/o_alu_select  registered operands/opcode to the ALU
//   o_alu_init     one-cycle multiply start pulse
//   i_alu_sal      8-bit ALU result
//   i_alu_cout     ALU carry/borrow out
//   i_alu_done     ALU multiply complete
//   o_out_valid    result available
//   i_out_ready    consumer takes the result
//   o_res          captured result
//   o_res_cout     captured carry
//   o_err_timeout  result was produced by the watchdog, not by the ALU
// -----------------------------------------------------------------------------
module alu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [3:0] i_op_a,
    input  logic [3:0] i_op_b,
    input  logic [1:0] i_op_sel,
    output logic [3:0] o_alu_a,
    output logic [3:0] o_alu_b,
    output logic [1:0] o_alu_select,
    output logic       o_alu_init,
    input  logic [7:0] i_alu_sal,
    input  logic       i_alu_cout,
    input  logic       i_alu_done,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_res,
    output logic       o_res_cout,
    output logic       o_err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_INIT = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL = 2'b10;

    // Last value of the WAIT counter; the watchdog fires when it is reached.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_alu_init;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [1:0] r_alu_select;
    logic [7:0] r_cnt;
    logic [7:0] r_res;
    logic       r_res_cout;

    logic       w_accept;
    logic       w_cap_done;
`ifdef ALU_CTRL_TIMEOUT_EN
    logic       r_err_timeout;
    logic       w_cap_to;
`endif

    // o_in_ready is registered, so it stays low while reset is asserted and
    // rises on the first edge after release; acceptance is qualified by it.
    assign w_accept = r_in_ready & i_in_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cap_done  = 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
        w_cap_to    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (i_op_sel == OP_MUL) ? S_INIT : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_HOLD;
            end
            S_INIT: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // r_cnt is 0 only in the first WAIT cycle: a done strobe seen
                // there may be left over from a previous multiply, so it is
                // ignored. Done has priority over the watchdog.
                if (i_alu_done && (r_cnt != 8'd0)) begin
                    w_cap_done  = 1'b1;
                    w_state_nxt = S_HOLD;
                end
`ifdef ALU_CTRL_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_cap_to    = 1'b1;
                    w_state_nxt = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and registered Moore outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_alu_init  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_HOLD);
            r_alu_init  <= (w_state_nxt == S_INIT);
        end
    end

    // -------------------------------------------------------------------------
    // Operand/opcode registers: loaded only on accept, so they stay stable
    // for the whole operation.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_select <= 2'b00;
        end else if (w_accept) begin
            r_alu_a      <= i_op_a;
            r_alu_b      <= i_op_b;
            r_alu_select <= i_op_sel;
        end
    end

    // -------------------------------------------------------------------------
    // WAIT counter: cleared in INIT, counts WAIT cycles. It saturates at
    // CNT_LAST so that, without the watchdog, an arbitrarily long wait never
    // wraps back to 0 (which would re-arm the stale-done guard).
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_INIT) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_WAIT) && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture. Multiply reports no carry; the full 8-bit ALU result is
    // kept unmodified for every opcode.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res      <= 8'd0;
            r_res_cout <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res      <= i_alu_sal;
            r_res_cout <= i_alu_cout;
        end else if (w_cap_done) begin
            r_res      <= i_alu_sal;
            r_res_cout <= 1'b0;
        end
`ifdef ALU_CTRL_TIMEOUT_EN
        else if (w_cap_to) begin
            r_res      <= 8'd0;
            r_res_cout <= 1'b0;
        end
`endif
    end

`ifdef ALU_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_timeout <= 1'b0;
        end else if ((r_state == S_EXEC) || w_cap_done) begin
            r_err_timeout <= 1'b0;
        end else if (w_cap_to) begin
            r_err_timeout <= 1'b1;
        end
    end

    assign o_err_timeout = r_err_timeout;
`else
    assign o_err_timeout = 1'b0;
`endif

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_alu_init   = r_alu_init;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_select = r_alu_select;
    assign o_res        = r_res;
    assign o_res_cout   = r_res_cout;

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl
//
// Directed testbench for alu_ctrl. A small behavioural ALU model drives
// i_alu_sal/i_alu_cout from the registered operands; i_alu_done is driven
// directly by the test tasks. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam int unsigned TO = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] op_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_select;
    logic       alu_init;
    logic [7:0] alu_sal;
    logic       alu_cout;
    logic       alu_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic       res_cout;
    logic       err_timeout;

    int errors = 0;
    int checks = 0;
    int init_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .i_op_sel     (op_sel),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_select (alu_select),
        .o_alu_init   (alu_init),
        .i_alu_sal    (alu_sal),
        .i_alu_cout   (alu_cout),
        .i_alu_done   (alu_done),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_res        (res),
        .o_res_cout   (res_cout),
        .o_err_timeout(err_timeout)
    );

    // Behavioural ALU: 4-bit add/sub with carry (sub carry = no-borrow),
    // 8-bit product (carry flag = upper nibble nonzero), bitwise and.
    logic [4:0] m_sum;
    logic [4:0] m_dif;
    logic [7:0] m_prod;
    always_comb begin
        m_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        m_dif  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        m_prod = {4'd0, alu_a} * {4'd0, alu_b};
        alu_sal  = 8'd0;
        alu_cout = 1'b0;
        case (alu_select)
            2'b00: begin alu_sal = {4'd0, m_sum[3:0]}; alu_cout = m_sum[4]; end
            2'b01: begin alu_sal = {4'd0, m_dif[3:0]}; alu_cout = m_dif[4]; end
            2'b10: begin alu_sal = m_prod; alu_cout = |m_prod[7:4]; end
            default: begin alu_sal = {4'd0, alu_a & alu_b}; alu_cout = 1'b0; end
        endcase
    end

    always @(posedge clk) if (alu_init === 1'b1) init_cnt <= init_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op_a = 4'd0; op_b = 4'd0; op_sel = 2'b00;
        alu_done = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++;
        if ({in_ready, out_valid, alu_init, alu_a, alu_b, alu_select, res, res_cout, err_timeout} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000000",
                     {in_ready, out_valid, alu_init, alu_a, alu_b, alu_select, res, res_cout, err_timeout});
        end
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b expected 0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        op_a = 4'd9; op_b = 4'd8; op_sel = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_edge1: got %b expected 0", out_valid); end
        checks++;
        if ({alu_a, alu_b, alu_select} !== 10'b1001_1000_00) begin
            errors++; $display("FAIL add_operands: got %h expected %h", {alu_a, alu_b, alu_select}, 10'b1001_1000_00);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL add_ready_busy: got %b expected 0", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid_edge2: got %b expected 1", out_valid); end
        checks++;
        if ({res, res_cout, err_timeout} !== {8'h01, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_result: got %h expected %h", {res, res_cout, err_timeout}, {8'h01, 1'b1, 1'b0});
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL add_return_idle: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_sub();
        int init_before;
        init_before = init_cnt;
        op_a = 4'd3; op_b = 4'd5; op_sel = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, res, res_cout} !== {1'b1, 8'h0E, 1'b0}) begin
            errors++; $display("FAIL sub_result: got %h expected %h", {out_valid, res, res_cout}, {1'b1, 8'h0E, 1'b0});
        end
        step();
        checks++;
        if (init_cnt !== init_before) begin
            errors++; $display("FAIL sub_no_init: got %0d pulses expected 0", init_cnt - init_before);
        end
    endtask

    task automatic test_and_hold();
        op_a = 4'hC; op_b = 4'hA; op_sel = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
        step();
        // A different request stays presented; it must be ignored until IDLE.
        op_a = 4'h1; op_b = 4'h1; op_sel = 2'b00;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready, res, alu_a} !== {1'b1, 1'b0, 8'h08, 4'hC}) begin
                errors++; $display("FAIL and_hold_cycle%0d: got %h expected %h", i,
                                   {out_valid, in_ready, res, alu_a}, {1'b1, 1'b0, 8'h08, 4'hC});
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready, alu_a} !== {1'b0, 1'b1, 4'hC}) begin
            errors++; $display("FAIL and_release: got %h expected %h", {out_valid, in_ready, alu_a}, {1'b0, 1'b1, 4'hC});
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int init_before;
        logic early;
        init_before = init_cnt;
        early = 1'b0;
        op_a = 4'd7; op_b = 4'd6; op_sel = 2'b10; in_valid = 1'b1; out_ready = 1'b0; alu_done = 1'b0;
        step();
        in_valid = 1'b0;
        checks++;
        if (alu_init !== 1'b1) begin errors++; $display("FAIL mul_init_high: got %b expected 1", alu_init); end
        step();
        // First WAIT cycle: present a stale done strobe.
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_stale_done: got %b expected 0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL mul_early_valid: got %b expected 0", early); end
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        checks++;
        if ({out_valid, res, res_cout, err_timeout} !== {1'b1, 8'h2A, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mul_result: got %h expected %h", {out_valid, res, res_cout, err_timeout},
                               {1'b1, 8'h2A, 1'b0, 1'b0});
        end
        checks++;
        if (init_cnt - init_before !== 1) begin
            errors++; $display("FAIL mul_init_pulses: got %0d expected 1", init_cnt - init_before);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_return_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_in_wait();
        op_a = 4'd7; op_b = 4'd6; op_sel = 2'b10; in_valid = 1'b1; out_ready = 1'b0; alu_done = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, alu_init, alu_a, alu_b, alu_select, res, res_cout, err_timeout} !== 23'd0) begin
            errors++;
            $display("FAIL wait_reset_outputs: got %h expected 000000",
                     {in_ready, out_valid, alu_init, alu_a, alu_b, alu_select, res, res_cout, err_timeout});
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL wait_reset_recover: got %b expected 10", {in_ready, out_valid});
        end
        // New request after reset: 2 + 3 = 5.
        op_a = 4'd2; op_b = 4'd3; op_sel = 2'b00; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, res, res_cout, err_timeout} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
            errors++; $display("FAIL wait_reset_next_op: got %h expected %h", {out_valid, res, res_cout, err_timeout},
                               {1'b1, 8'h05, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        op_a = 4'd5; op_b = 4'd5; op_sel = 2'b10; in_valid = 1'b1; out_ready = 1'b0; alu_done = 1'b0;
        step();
        in_valid = 1'b0;
        step();
`ifdef ALU_CTRL_TIMEOUT_EN
        for (int i = 0; i < 31; i++) begin
            step();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", early); end
        step();
        checks++;
        if ({out_valid, err_timeout, res, res_cout} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL timeout_result: got %h expected %h", {out_valid, err_timeout, res, res_cout},
                               {1'b1, 1'b1, 8'h00, 1'b0});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL timeout_return_idle: got %b expected 1", in_ready); end
`else
        for (int i = 0; i < 120; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
        end
        checks++;
        if ({early, err_timeout} !== 2'b00) begin
            errors++; $display("FAIL no_timeout_stays_wait: got %b expected 00", {early, err_timeout});
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL no_timeout_recover: got %b expected 1", in_ready); end
`endif
    endtask

    task automatic test_back_to_back();
        op_a = 4'hC; op_b = 4'hA; op_sel = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
        step();
        op_a = 4'd6; op_b = 4'd7; op_sel = 2'b00;
        step();
        checks++;
        if ({out_valid, res, err_timeout} !== {1'b1, 8'h08, 1'b0}) begin
            errors++; $display("FAIL b2b_first: got %h expected %h", {out_valid, res, err_timeout}, {1'b1, 8'h08, 1'b0});
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, alu_a} !== {1'b1, 4'hC}) begin
            errors++; $display("FAIL b2b_idle: got %h expected %h", {in_ready, alu_a}, {1'b1, 4'hC});
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, alu_a, alu_b} !== {1'b0, 4'd6, 4'd7}) begin
            errors++; $display("FAIL b2b_second_accept: got %h expected %h", {in_ready, alu_a, alu_b}, {1'b0, 4'd6, 4'd7});
        end
        step();
        checks++;
        if ({out_valid, res, res_cout} !== {1'b1, 8'h0D, 1'b0}) begin
            errors++; $display("FAIL b2b_second_result: got %h expected %h", {out_valid, res, res_cout}, {1'b1, 8'h0D, 1'b0});
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_and_hold();
        test_mul();
        test_reset_in_wait();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
